card_pile_mgr: RTL and testbench

CARD_PILE_MGR -- requirements
Module: card_pile_mgr

---
 rtl/card_pkg.sv | 23 ++
 rtl/card_ram.sv | 23 ++
 rtl/card_pile_mgr.sv | 222 ++++++++++++++++++++++
 tb/tb_card_pile_mgr.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared definitions for the card pile manager: command opcodes, FSM states
// and default card field widths.
package card_pkg;

  localparam int DEF_VAL_W  = 4;
  localparam int DEF_SUIT_W = 2;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_MOVE = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_e;

endpackage

// File: rtl/card_ram.sv
// Synchronous single-port card memory, read-first, one cycle read latency.
module card_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 12
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/card_pile_mgr.sv
// Linked-list card pile manager: N_PILES LIFO piles plus a free list sharing
// one card RAM whose words are {suit, value, next}.
module card_pile_mgr
  import card_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int N_PILES = 4,
  parameter int VAL_W   = DEF_VAL_W,
  parameter int SUIT_W  = DEF_SUIT_W,
  localparam int SRC_W  = (N_PILES > 1) ? $clog2(N_PILES) : 1,
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [SRC_W-1:0]         cmd_src,
  input  logic [SRC_W-1:0]         cmd_dst,
  input  logic [VAL_W-1:0]         cmd_value,
  input  logic [SUIT_W-1:0]        cmd_suit,
  output logic                     resp_valid,
  output logic                     resp_error,
  output logic [VAL_W-1:0]         resp_value,
  output logic [SUIT_W-1:0]        resp_suit,
  output logic [N_PILES*CNT_W-1:0] pile_count,
  output logic [CNT_W-1:0]         free_count
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = SUIT_W + VAL_W + ADDR_W;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] init_idx_q, init_idx_d;
  logic [ADDR_W-1:0] head_q [N_PILES];
  logic [ADDR_W-1:0] head_d [N_PILES];
  logic [CNT_W-1:0]  count_q [N_PILES];
  logic [CNT_W-1:0]  count_d [N_PILES];
  logic [ADDR_W-1:0] free_head_q, free_head_d;
  logic [CNT_W-1:0]  free_count_q, free_count_d;
  op_e               op_q, op_d;
  logic [SRC_W-1:0]  src_q, src_d, dst_q, dst_d;
  logic [VAL_W-1:0]  val_q, val_d, rsp_val_q, rsp_val_d;
  logic [SUIT_W-1:0] suit_q, suit_d, rsp_suit_q, rsp_suit_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr, slot, init_next;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] rd_next;
  logic [VAL_W-1:0]  rd_val;
  logic [SUIT_W-1:0] rd_suit;

  card_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign rd_next   = ram_rdata[ADDR_W-1:0];
  assign rd_val    = ram_rdata[ADDR_W +: VAL_W];
  assign rd_suit   = ram_rdata[ADDR_W+VAL_W +: SUIT_W];
  assign init_next = init_idx_q + ADDR_W'(1);
  // Every command reads and then rewrites the same slot, so RD and WR share one address.
  assign slot      = (op_q == OP_PUSH) ? free_head_q : head_q[src_q];
  assign ram_addr  = (state_q == INIT) ? init_idx_q : slot;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_idx_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      IDLE:    if (cmd_valid) state_d = RD;
      RD:      state_d = WR;
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE);
    resp_valid = (state_q == RSP);
    resp_error = (state_q == RSP) && err_q;
    resp_value = (state_q == RSP) ? rsp_val_q : '0;
    resp_suit  = (state_q == RSP) ? rsp_suit_q : '0;
    free_count = free_count_q;
    pile_count = '0;
    for (int i = 0; i < N_PILES; i++) pile_count[i*CNT_W +: CNT_W] = count_q[i];
  end

  always_comb begin
    init_idx_d   = init_idx_q;
    head_d       = head_q;
    count_d      = count_q;
    free_head_d  = free_head_q;
    free_count_d = free_count_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    val_d        = val_q;
    suit_d       = suit_q;
    err_d        = err_q;
    rsp_val_d    = rsp_val_q;
    rsp_suit_d   = rsp_suit_q;
    ram_we       = 1'b0;
    ram_wdata    = '0;
    case (state_q)
      INIT: begin
        ram_we     = 1'b1;
        ram_wdata  = {SUIT_W'(0), VAL_W'(0), init_next};
        init_idx_d = init_next;
        if (init_idx_q == ADDR_W'(DEPTH - 1)) begin
          free_head_d  = '0;
          free_count_d = CNT_W'(DEPTH);
          for (int i = 0; i < N_PILES; i++) begin
            head_d[i]  = '0;
            count_d[i] = '0;
          end
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          op_d       = op_e'(cmd_op);
          src_d      = cmd_src;
          dst_d      = cmd_dst;
          val_d      = cmd_value;
          suit_d     = cmd_suit;
          rsp_val_d  = '0;
          rsp_suit_d = '0;
          case (op_e'(cmd_op))
            OP_PUSH: err_d = (free_count_q == '0);
            OP_POP,
            OP_MOVE: err_d = (count_q[cmd_src] == '0);
            default: err_d = 1'b1;
          endcase
        end
      end
      WR: begin
        if (!err_q) begin
          case (op_q)
            OP_PUSH: begin
              ram_we              = 1'b1;
              ram_wdata           = {suit_q, val_q, head_q[src_q]};
              free_head_d         = rd_next;
              head_d[src_q]       = free_head_q;
              count_d[src_q]      = count_q[src_q] + CNT_W'(1);
              free_count_d        = free_count_q - CNT_W'(1);
            end
            OP_POP: begin
              ram_we              = 1'b1;
              ram_wdata           = {rd_suit, rd_val, free_head_q};
              head_d[src_q]       = rd_next;
              free_head_d         = head_q[src_q];
              count_d[src_q]      = count_q[src_q] - CNT_W'(1);
              free_count_d        = free_count_q + CNT_W'(1);
              rsp_val_d           = rd_val;
              rsp_suit_d          = rd_suit;
            end
            OP_MOVE: begin
              rsp_val_d           = rd_val;
              rsp_suit_d          = rd_suit;
              // Moving onto the same pile only peeks at the top card.
              if (src_q != dst_q) begin
                ram_we            = 1'b1;
                ram_wdata         = {rd_suit, rd_val, head_q[dst_q]};
                head_d[src_q]     = rd_next;
                head_d[dst_q]     = head_q[src_q];
                count_d[src_q]    = count_q[src_q] - CNT_W'(1);
                count_d[dst_q]    = count_q[dst_q] + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_idx_q   <= '0;
      free_head_q  <= '0;
      free_count_q <= '0;
      for (int i = 0; i < N_PILES; i++) begin
        head_q[i]  <= '0;
        count_q[i] <= '0;
      end
      op_q       <= OP_PUSH;
      src_q      <= '0;
      dst_q      <= '0;
      val_q      <= '0;
      suit_q     <= '0;
      err_q      <= 1'b0;
      rsp_val_q  <= '0;
      rsp_suit_q <= '0;
    end else begin
      init_idx_q   <= init_idx_d;
      free_head_q  <= free_head_d;
      free_count_q <= free_count_d;
      head_q       <= head_d;
      count_q      <= count_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      val_q        <= val_d;
      suit_q       <= suit_d;
      err_q        <= err_d;
      rsp_val_q    <= rsp_val_d;
      rsp_suit_q   <= rsp_suit_d;
    end
  end

endmodule

// File: tb/tb_card_pile_mgr.sv
// Randomized bench for card_pile_mgr against a stack-per-pile reference model.
module tb_card_pile_mgr;

  localparam int ADDR_W  = 6;
  localparam int N_PILES = 4;
  localparam int DEPTH   = 64;
  localparam int CNT_W   = ADDR_W + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_src = '0, cmd_dst = '0;
  logic [3:0] cmd_value = '0;
  logic [1:0] cmd_suit = '0;
  logic resp_valid, resp_error;
  logic [3:0] resp_value;
  logic [1:0] resp_suit;
  logic [N_PILES*CNT_W-1:0] pile_count;
  logic [CNT_W-1:0] free_count;

  int check_count = 0;
  int pass_count  = 0;

  logic [5:0] stk [N_PILES][DEPTH];
  int         cnt [N_PILES];

  card_pile_mgr dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_value(cmd_value), .cmd_suit(cmd_suit),
    .resp_valid(resp_valid), .resp_error(resp_error),
    .resp_value(resp_value), .resp_suit(resp_suit),
    .pile_count(pile_count), .free_count(free_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int modelTotal();
    int t = 0;
    for (int p = 0; p < N_PILES; p++) t += cnt[p];
    return t;
  endfunction

  function automatic logic [31:0] modelPileVec();
    logic [31:0] v = '0;
    for (int p = 0; p < N_PILES; p++) v[p*CNT_W +: CNT_W] = CNT_W'(cnt[p]);
    return v;
  endfunction

  // Issue one command at a falling edge, then track the response window cycle by cycle.
  task automatic applyStimulus(input logic [1:0] op, input int src, input int dst,
                               input logic [3:0] val, input logic [1:0] suit);
    int waited = 0;
    logic exp_err = 1'b0;
    logic [5:0] exp_card = '0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    case (op)
      2'd0: if (modelTotal() == DEPTH) exp_err = 1'b1;
            else begin stk[src][cnt[src]] = {suit, val}; cnt[src]++; end
      2'd1: if (cnt[src] == 0) exp_err = 1'b1;
            else begin cnt[src]--; exp_card = stk[src][cnt[src]]; end
      2'd2: if (cnt[src] == 0) exp_err = 1'b1;
            else begin
              exp_card = stk[src][cnt[src]-1];
              if (src != dst) begin
                cnt[src]--;
                stk[dst][cnt[dst]] = exp_card;
                cnt[dst]++;
              end
            end
      default: exp_err = 1'b1;
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = 2'(src);
    cmd_dst   = 2'(dst);
    cmd_value = val;
    cmd_suit  = suit;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom);
    cmd_src   = 2'($urandom);
    cmd_dst   = 2'($urandom);
    cmd_value = 4'($urandom);
    cmd_suit  = 2'($urandom);
    @(negedge clock);
    checkOutput("rd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rd_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    checkOutput("wr_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clock);
    checkOutput("rsp_valid", 32'(resp_valid), 32'd1);
    checkOutput("rsp_error", 32'(resp_error), 32'(exp_err));
    checkOutput("rsp_card", 32'({resp_suit, resp_value}), 32'(exp_card));
    checkOutput("free_count", 32'(free_count), 32'(DEPTH - modelTotal()));
    checkOutput("pile_count", 32'(pile_count), modelPileVec());
    cmd_valid = 1'b0;
    @(negedge clock);
    checkOutput("post_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic resetAndCheck();
    int waited = 0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
      checkOutput("rst_resp", 32'({resp_valid, resp_error, resp_suit, resp_value}), 32'd0);
      checkOutput("rst_free", 32'(free_count), 32'd0);
      checkOutput("rst_piles", 32'(pile_count), 32'd0);
    end
    reset = 1'b0;
    for (int p = 0; p < N_PILES; p++) cnt[p] = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("ready_latency", 32'(waited), 32'(DEPTH));
    checkOutput("init_free", 32'(free_count), 32'(DEPTH));
    checkOutput("init_piles", 32'(pile_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int p = 0; p < N_PILES; p++) cnt[p] = 0;
    resetAndCheck();

    applyStimulus(2'd0, 0, 0, 4'd5, 2'd1);
    applyStimulus(2'd0, 0, 0, 4'd9, 2'd2);
    applyStimulus(2'd1, 0, 0, 4'd0, 2'd0);
    applyStimulus(2'd1, 0, 0, 4'd0, 2'd0);
    applyStimulus(2'd1, 2, 0, 4'd0, 2'd0);
    applyStimulus(2'd3, 1, 2, 4'd7, 2'd3);
    applyStimulus(2'd2, 1, 2, 4'd0, 2'd0);
    applyStimulus(2'd0, 0, 0, 4'd3, 2'd0);
    applyStimulus(2'd2, 0, 3, 4'd0, 2'd0);
    applyStimulus(2'd2, 3, 3, 4'd0, 2'd0);
    applyStimulus(2'd1, 3, 0, 4'd0, 2'd0);

    for (int i = 0; i < 250; i++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      applyStimulus(op, $urandom_range(0, 3), $urandom_range(0, 3),
                    4'($urandom), 2'($urandom));
    end

    while (!cmd_ready) @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_src   = 2'd0;
    cmd_value = 4'd6;
    cmd_suit  = 2'd1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetAndCheck();

    for (int i = 0; i < DEPTH; i++) applyStimulus(2'd0, 1, 0, 4'($urandom), 2'($urandom));
    applyStimulus(2'd0, 1, 0, 4'd1, 2'd1);
    applyStimulus(2'd0, 2, 0, 4'd2, 2'd2);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0) ? 2'd1 : 2'd2, $urandom_range(0, 3),
                    $urandom_range(0, 3), 4'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
